// File: rtl/nfc_pkg.sv
// nfc_pkg: shared FSM/sub-step encodings and limits for the NAND command/address latch sequencer.
package nfc_pkg;
   localparam int MaxAddrCount = 5;
   typedef enum logic [2:0] {StIdle, StCmd, StAddr, StCmd2, StTail} stateT;
   typedef enum logic [1:0] {StepIdle, StepSetup, StepWLow, StepWHigh} stepT;
   function automatic logic [2:0] clampAddrCount(input logic [2:0] count);
      return (count > 3'(MaxAddrCount)) ? 3'(MaxAddrCount) : count;
   endfunction
endpackage

// File: rtl/nfc_we_pulse_timer.sv
// nfc_we_pulse_timer: SETUP/WLOW/WHIGH down-counter for one WE# byte phase, or a bare WHIGH hold for the tail.
module nfc_we_pulse_timer
   import nfc_pkg::*;
#(
   parameter int SetupCycles = 2,
   parameter int PulseCycles = 2
) (
   input  logic iSystemClock,
   input  logic iModuleReset,
   input  logic iLoadByte,
   input  logic iLoadTail,
   output stepT oStep,
   output logic oPhaseEnd
);
   stepT step;
   logic [7:0] count;
   always_ff @(posedge iSystemClock or posedge iModuleReset)
      if (iModuleReset) begin
         step <= StepIdle;
         count <= '0;
      end else if (iLoadByte) begin
         step <= StepSetup;
         count <= 8'(SetupCycles - 1);
      end else if (iLoadTail) begin
         step <= StepWHigh;
         count <= 8'(PulseCycles - 1);
      end else if (count != 8'd0) begin
         count <= count - 8'd1;
      end else if (step == StepSetup || step == StepWLow) begin
         step <= (step == StepSetup) ? StepWLow : StepWHigh;
         count <= 8'(PulseCycles - 1);
      end else begin
         step <= StepIdle;
      end
   assign oStep = step;
   assign oPhaseEnd = (step == StepWHigh) && (count == 8'd0);
endmodule

// File: rtl/nfc_cmd_addr_latch.sv
// nfc_cmd_addr_latch: drives one NAND command + 0..5 address cycles onto the PHY with CLE/ALE/WE# timing.
// Build option NFC_CMDADDR_CMD2_EN adds iCommand2/iUseCmd2 and a second command phase before the tail.
module nfc_cmd_addr_latch
   import nfc_pkg::*;
#(
   parameter int NumberOfWays = 4,
   parameter int SetupCycles = 2,
   parameter int PulseCycles = 2
) (
   input  logic                      iSystemClock,
   input  logic                      iModuleReset,
   input  logic                      iStart,
   input  logic [NumberOfWays-1:0]   iTargetWay,
   input  logic [7:0]                iCommand,
   input  logic [2:0]                iAddrCount,
   input  logic [39:0]               iAddress,
`ifdef NFC_CMDADDR_CMD2_EN
   input  logic [7:0]                iCommand2,
   input  logic                      iUseCmd2,
`endif
   output logic                      oReady,
   output logic                      oDone,
   output logic                      oDQOutEnable,
   output logic [31:0]               oPO_DQ,
   output logic [2*NumberOfWays-1:0] oPO_ChipEnable,
   output logic [3:0]                oPO_WriteEnable,
   output logic [3:0]                oPO_CommandLatchEnable,
   output logic [3:0]                oPO_AddressLatchEnable,
   output logic [3:0]                oPO_ReadEnable
);
   stateT state, nextState, lastState;
   stepT step;
   logic phaseEnd, accept, loadByte, loadTail, byteCycle;
   logic [NumberOfWays-1:0] wayR, ceR;
   logic [7:0] cmdR, cmd2Byte, dqNext, dqR;
   logic [MaxAddrCount-1:0][7:0] addrR;
   logic [2:0] countR, index, nextIndex;
   logic weR, cleR, aleR;

   assign accept = iStart & oReady;

`ifdef NFC_CMDADDR_CMD2_EN
   logic [7:0] cmd2R;
   logic useCmd2R;
   always_ff @(posedge iSystemClock or posedge iModuleReset)
      if (iModuleReset) begin
         cmd2R <= '0;
         useCmd2R <= 1'b0;
      end else if (accept) begin
         cmd2R <= iCommand2;
         useCmd2R <= iUseCmd2;
      end
   assign cmd2Byte = cmd2R;
   assign lastState = useCmd2R ? StCmd2 : StTail;
`else
   assign cmd2Byte = 8'h00;
   assign lastState = StTail;
`endif

   nfc_we_pulse_timer #(
      .SetupCycles(SetupCycles),
      .PulseCycles(PulseCycles)
   ) weTimer (
      .iSystemClock(iSystemClock),
      .iModuleReset(iModuleReset),
      .iLoadByte(loadByte),
      .iLoadTail(loadTail),
      .oStep(step),
      .oPhaseEnd(phaseEnd)
   );

   always_ff @(posedge iSystemClock or posedge iModuleReset)
      if (iModuleReset) begin
         wayR <= '0;
         cmdR <= '0;
         addrR <= '0;
         countR <= '0;
      end else if (accept) begin
         wayR <= iTargetWay;
         cmdR <= iCommand;
         addrR <= iAddress;
         countR <= clampAddrCount(iAddrCount);
      end

   always_ff @(posedge iSystemClock or posedge iModuleReset)
      if (iModuleReset) begin
         state <= StIdle;
         index <= '0;
      end else begin
         state <= nextState;
         index <= nextIndex;
      end

   // The last byte phase (command with no address, or final address) hands over to lastState.
   always_comb begin
      nextState = state;
      nextIndex = index;
      loadByte = 1'b0;
      loadTail = 1'b0;
      case (state)
         StIdle:
            if (accept) begin
               nextState = StCmd;
               loadByte = 1'b1;
            end
         StCmd, StAddr:
            if (phaseEnd) begin
               if ((state == StCmd) ? (countR == 3'd0) : (index == countR - 3'd1)) begin
                  nextState = lastState;
                  loadByte = (lastState == StCmd2);
                  loadTail = (lastState == StTail);
               end else begin
                  nextState = StAddr;
                  nextIndex = (state == StCmd) ? 3'd0 : index + 3'd1;
                  loadByte = 1'b1;
               end
            end
`ifdef NFC_CMDADDR_CMD2_EN
         StCmd2:
            if (phaseEnd) begin
               nextState = StTail;
               loadTail = 1'b1;
            end
`endif
         StTail:
            if (phaseEnd) nextState = StIdle;
         default:
            nextState = StIdle;
      endcase
   end

   assign byteCycle = (state == StCmd) || (state == StAddr) || (state == StCmd2);
   assign dqNext = (state == StCmd) ? cmdR :
                   (state == StAddr) ? addrR[index] :
                   (state == StCmd2) ? cmd2Byte : 8'h00;

   // Pins trail the FSM by one register stage; oDone fires on the first IDLE cycle after a busy run.
   always_ff @(posedge iSystemClock or posedge iModuleReset)
      if (iModuleReset) begin
         oReady <= 1'b1;
         oDone <= 1'b0;
         oDQOutEnable <= 1'b0;
         ceR <= '1;
         weR <= 1'b1;
         cleR <= 1'b0;
         aleR <= 1'b0;
         dqR <= '0;
      end else begin
         oReady <= (state == StIdle) && !accept;
         oDone <= (state == StIdle) && !oReady;
         oDQOutEnable <= byteCycle;
         ceR <= accept ? ~iTargetWay : (state == StIdle) ? '1 : ~wayR;
         weR <= !(byteCycle && step == StepWLow);
         cleR <= (state == StCmd) || (state == StCmd2);
         aleR <= (state == StAddr);
         dqR <= dqNext;
      end

   assign oPO_DQ = {8'h00, dqR, 8'h00, dqR};
   assign oPO_ChipEnable = {ceR, ceR};
   assign oPO_WriteEnable = {2'b00, weR, weR};
   assign oPO_CommandLatchEnable = {2'b00, cleR, cleR};
   assign oPO_AddressLatchEnable = {2'b00, aleR, aleR};
   assign oPO_ReadEnable = 4'b0011;
endmodule

// File: doc/nfc_cmd_addr_latch.md
NFC_CMD_ADDR_LATCH -- requirements
Module: nfc_cmd_addr_latch

Interface
REQ-001 SHALL have parameter NumberOfWays, default 4, number of chip-enable ways.
REQ-002 SHALL have parameter SetupCycles, default 2, iSystemClock cycles that CLE/ALE/DQ are held before each WE# low.
REQ-003 SHALL have parameter PulseCycles, default 2, cycles WE# is low (tWP) and also cycles WE# is high after each pulse (tWH).
REQ-004 iSystemClock  in  1  single clock; all logic on its rising edge.
REQ-005 iModuleReset  in  1  asynchronous, active-high reset.
REQ-006 iStart  in  1  request pulse; accepted only when oReady=1.
REQ-007 iTargetWay  in  NumberOfWays  one-hot way select, sampled on accept.
REQ-008 iCommand  in  8  first command byte, sampled on accept.
REQ-009 iAddrCount  in  3  address cycles, 0..5, sampled on accept; values 6..7 are treated as 5.
REQ-010 iAddress  in  40  address bytes, byte 0 = [7:0] sent first, sampled on accept.
REQ-011 oReady  out  1  high in IDLE only.
REQ-012 oDone  out  1  one-cycle pulse when the sequence completes.
REQ-013 oDQOutEnable  out  1  DQ drive enable toward the physical output stage.
REQ-014 oPO_DQ  out  32  [7:0] and [23:16] both carry the current byte; other bits 0.
REQ-015 oPO_ChipEnable  out  2*NumberOfWays  active-low CE per way, low half [NumberOfWays-1:0] used, upper half mirrors it.
REQ-016 oPO_WriteEnable, oPO_CommandLatchEnable, oPO_AddressLatchEnable  out  4 each  half-res vectors; bits [1:0] both carry the level, [3:2] = 0.
REQ-017 oPO_ReadEnable  out  4  constant 4'b0011 (RE# idle high).

Function
REQ-018 States SHALL be IDLE, CMD, ADDR, CMD2, TAIL; every byte phase runs sub-steps SETUP (SetupCycles), WLOW (PulseCycles), WHIGH (PulseCycles) via one down-counter.
REQ-019 IDLE: on iStart&oReady latch inputs, drive selected CE# low, go CMD/SETUP next cycle.
REQ-020 CMD: CLE=1, ALE=0, DQ=command, oDQOutEnable=1; WE#=0 only during WLOW.
REQ-021 After CMD WHIGH: iAddrCount=0 -> CMD2 (if compiled) else TAIL; otherwise ADDR with byte index 0.
REQ-022 ADDR: CLE=0, ALE=1, DQ=address byte[index]; after WHIGH increment index; index==count-1 exits as REQ-021.
REQ-023 TAIL: CLE=ALE=0, oDQOutEnable=0, CE# kept low for PulseCycles, then oDone=1 for one cycle, CE# all high, return IDLE.
REQ-024 Total cycles accept->oDone SHALL be 1 + (1+n[+1])*(SetupCycles+2*PulseCycles) + PulseCycles, n = address count.
REQ-025 iStart while oReady=0 SHALL be ignored; no queuing.
REQ-026 CLE and ALE SHALL never be high in the same cycle; WE# SHALL change only while CLE/ALE/DQ are stable.
REQ-027 Outputs SHALL be registered; no combinational path input->output.

Reset
REQ-028 Reset SHALL force IDLE, oReady=1, oDone=0, oDQOutEnable=0, CE# all 1, WE# 1 (bits [1:0]=2'b11), CLE=ALE=0, oPO_DQ=0, counters 0.
REQ-029 Reset mid-sequence SHALL abort immediately with the REQ-028 values; no oDone.

Configuration
REQ-030 Macro NFC_CMDADDR_CMD2_EN: when defined, ports iCommand2 (8, in) and iUseCmd2 (1, in, sampled on accept) exist; iUseCmd2=1 inserts CMD2 phase (CLE=1, DQ=iCommand2) before TAIL.
REQ-031 Without NFC_CMDADDR_CMD2_EN, ports and CMD2 state are absent; flow goes directly to TAIL.

Structure
REQ-032 State encodings, sub-step encodings and max address count (5) SHALL live in shared package nfc_pkg.
REQ-033 One sub-module nfc_we_pulse_timer SHALL implement the SETUP/WLOW/WHIGH counter, reporting step and phase-end.

Verification
REQ-034 Reset asserted mid-ADDR byte 2 -> next edge all outputs at REQ-028 values, oReady=1, no oDone.
REQ-035 iCommand=0xFF, iAddrCount=0, way 4'b0001 -> one WE# pulse with CLE=1, DQ=0xFF, CE#[0]=0; oDone 9 cycles after accept (defaults).
REQ-036 iCommand=0x00, iAddrCount=5, iAddress=0x0403020100 -> 6 WE# pulses, DQ 0x00 (CLE) then 0x00..0x04 (ALE); oDone 39 cycles after accept.
REQ-037 With NFC_CMDADDR_CMD2_EN, iUseCmd2=1, iCommand2=0x30, 5 addresses -> 7th pulse CLE=1 DQ=0x30; oDone at 45 cycles.
REQ-038 iStart pulsed during a busy sequence -> ignored, only one oDone.
REQ-039 Assertion across all tests: CLE&ALE never 1; WE# low width exactly PulseCycles; one-hot CE# only while busy.
